// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the execute-stage ALU: captures decoded
// operands/controls, forwards EX/MEM and MEM/WB results, and detects load-use hazards.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [15:0] id_A,
  input  logic [15:0] id_B,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_useRs,
  input  logic        id_useRt,
  input  logic [2:0]  id_Op,
  input  logic        id_invA,
  input  logic        id_invB,
  input  logic        id_sign,
  input  logic        id_Cin,
  input  logic        id_subOP,
  input  logic [2:0]  id_rd,
  input  logic        id_regWrite,
  input  logic        id_memRead,
  input  logic        exmem_regWrite,
  input  logic [2:0]  exmem_rd,
  input  logic [15:0] exmem_result,
  input  logic        memwb_regWrite,
  input  logic [2:0]  memwb_rd,
  input  logic [15:0] memwb_data,
  input  logic        stall_ext,
  input  logic        flush,
  output logic        ex_valid,
  output logic [15:0] ex_A,
  output logic [15:0] ex_B,
  output logic [2:0]  ex_Op,
  output logic        ex_invA,
  output logic        ex_invB,
  output logic        ex_sign,
  output logic        ex_Cin,
  output logic        ex_subOP,
  output logic [2:0]  ex_rd,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        hazard_stall
);

  logic        validQ;
  logic [15:0] aQ, bQ;
  logic [2:0]  rsQ, rtQ, opQ, rdQ;
  logic        useRsQ, useRtQ;
  logic        invAQ, invBQ, signQ, cinQ, subOpQ;
  logic        regWriteQ, memReadQ;

  logic        loadUse;
  logic [15:0] capA, capB;

  always_comb begin
    loadUse = id_valid && validQ && memReadQ && regWriteQ &&
              ((id_useRs && (id_rs == rdQ)) || (id_useRt && (id_rt == rdQ)));
    // Register-file write-through: same-cycle writeback wins over the stale read.
    capA = (memwb_regWrite && id_useRs && (memwb_rd == id_rs)) ? memwb_data : id_A;
    capB = (memwb_regWrite && id_useRt && (memwb_rd == id_rt)) ? memwb_data : id_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ    <= 1'b0;
      aQ        <= '0;
      bQ        <= '0;
      rsQ       <= '0;
      rtQ       <= '0;
      useRsQ    <= 1'b0;
      useRtQ    <= 1'b0;
      opQ       <= '0;
      invAQ     <= 1'b0;
      invBQ     <= 1'b0;
      signQ     <= 1'b0;
      cinQ      <= 1'b0;
      subOpQ    <= 1'b0;
      rdQ       <= '0;
      regWriteQ <= 1'b0;
      memReadQ  <= 1'b0;
    end else if (flush || (!stall_ext && loadUse)) begin
      validQ    <= 1'b0;
      regWriteQ <= 1'b0;
      memReadQ  <= 1'b0;
    end else if (!stall_ext) begin
      validQ    <= id_valid;
      aQ        <= capA;
      bQ        <= capB;
      rsQ       <= id_rs;
      rtQ       <= id_rt;
      useRsQ    <= id_useRs;
      useRtQ    <= id_useRt;
      opQ       <= id_Op;
      invAQ     <= id_invA;
      invBQ     <= id_invB;
      signQ     <= id_sign;
      cinQ      <= id_Cin;
      subOpQ    <= id_subOP;
      rdQ       <= id_rd;
      // Side-effect controls never survive without a valid instruction.
      regWriteQ <= id_valid && id_regWrite;
      memReadQ  <= id_valid && id_memRead;
    end
  end

  always_comb begin
    ex_A = aQ;
    if (exmem_regWrite && useRsQ && (exmem_rd == rsQ))
      ex_A = exmem_result;
    else if (memwb_regWrite && useRsQ && (memwb_rd == rsQ))
      ex_A = memwb_data;

    ex_B = bQ;
    if (exmem_regWrite && useRtQ && (exmem_rd == rtQ))
      ex_B = exmem_result;
    else if (memwb_regWrite && useRtQ && (memwb_rd == rtQ))
      ex_B = memwb_data;
  end

  assign ex_valid     = validQ;
  assign ex_Op        = opQ;
  assign ex_invA      = invAQ;
  assign ex_invB      = invBQ;
  assign ex_sign      = signQ;
  assign ex_Cin       = cinQ;
  assign ex_subOP     = subOpQ;
  assign ex_rd        = rdQ;
  assign ex_regWrite  = regWriteQ;
  assign ex_memRead   = memReadQ;
  assign hazard_stall = loadUse;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding, load-use, bypass,
// stall/flush and immediate operands, each scenario in its own task.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_A, id_B;
  logic [2:0]  id_rs, id_rt;
  logic        id_useRs, id_useRt;
  logic [2:0]  id_Op;
  logic        id_invA, id_invB, id_sign, id_Cin, id_subOP;
  logic [2:0]  id_rd;
  logic        id_regWrite, id_memRead;
  logic        exmem_regWrite;
  logic [2:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_regWrite;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_data;
  logic        stall_ext, flush;
  logic        ex_valid;
  logic [15:0] ex_A, ex_B;
  logic [2:0]  ex_Op;
  logic        ex_invA, ex_invB, ex_sign, ex_Cin, ex_subOP;
  logic [2:0]  ex_rd;
  logic        ex_regWrite, ex_memRead;
  logic        hazard_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_A(id_A), .id_B(id_B),
    .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
    .id_Op(id_Op), .id_invA(id_invA), .id_invB(id_invB), .id_sign(id_sign),
    .id_Cin(id_Cin), .id_subOP(id_subOP), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall_ext(stall_ext), .flush(flush),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_Op(ex_Op),
    .ex_invA(ex_invA), .ex_invB(ex_invB), .ex_sign(ex_sign), .ex_Cin(ex_Cin),
    .ex_subOP(ex_subOP), .ex_rd(ex_rd),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .hazard_stall(hazard_stall)
  );

  task automatic clearInputs();
    id_valid = 0; id_A = '0; id_B = '0; id_rs = '0; id_rt = '0;
    id_useRs = 0; id_useRt = 0; id_Op = '0; id_invA = 0; id_invB = 0;
    id_sign = 0; id_Cin = 0; id_subOP = 0; id_rd = '0;
    id_regWrite = 0; id_memRead = 0;
    exmem_regWrite = 0; exmem_rd = '0; exmem_result = '0;
    memwb_regWrite = 0; memwb_rd = '0; memwb_data = '0;
    stall_ext = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    id_valid = 1; id_A = 16'hABCD; id_B = 16'h4321; id_Op = 3'b111;
    tick();
    checks++;
    if (ex_A !== 16'hABCD) begin errors++; $display("FAIL pre_reset_A got %h want ABCD", ex_A); end
    #3 rst_n = 0;
    #1;
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    checks++;
    if (ex_Op !== 3'b000) begin errors++; $display("FAIL reset_Op got %b want 000", ex_Op); end
    checks++;
    if (ex_A !== 16'h0000 || ex_B !== 16'h0000) begin
      errors++; $display("FAIL reset_AB got %h/%h want 0000/0000", ex_A, ex_B);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", hazard_stall); end
    @(negedge clk);
    rst_n = 1;
    id_A = 16'h1234; id_Op = 3'b100; id_B = '0;
    tick();
    checks++;
    if (ex_A !== 16'h1234 || ex_Op !== 3'b100 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_capture got A=%h Op=%b v=%b want 1234 100 1", ex_A, ex_Op, ex_valid);
    end
  endtask

  task automatic test_forward_priority();
    clearInputs();
    id_valid = 1; id_A = 16'h0001; id_rs = 3; id_useRs = 1;
    tick();
    checks++;
    if (ex_A !== 16'h0001) begin errors++; $display("FAIL fwd_none got %h want 0001", ex_A); end
    exmem_regWrite = 1; exmem_rd = 3; exmem_result = 16'hAAAA;
    memwb_regWrite = 1; memwb_rd = 3; memwb_data = 16'h5555;
    #1;
    checks++;
    if (ex_A !== 16'hAAAA) begin errors++; $display("FAIL fwd_exmem_prio got %h want AAAA", ex_A); end
    exmem_regWrite = 0;
    #1;
    checks++;
    if (ex_A !== 16'h5555) begin errors++; $display("FAIL fwd_memwb got %h want 5555", ex_A); end
    // r0 on the B path forwards like any other index
    clearInputs();
    id_valid = 1; id_B = 16'h0101; id_rt = 0; id_useRt = 1;
    tick();
    exmem_regWrite = 1; exmem_rd = 0; exmem_result = 16'hC0DE;
    #1;
    checks++;
    if (ex_B !== 16'hC0DE) begin errors++; $display("FAIL fwd_r0_B got %h want C0DE", ex_B); end
  endtask

  task automatic test_load_use();
    clearInputs();
    id_valid = 1; id_rd = 2; id_regWrite = 1; id_memRead = 1;
    tick();
    checks++;
    if (ex_memRead !== 1'b1 || ex_rd !== 3'd2) begin
      errors++; $display("FAIL load_in_ex got mr=%b rd=%0d want 1 2", ex_memRead, ex_rd);
    end
    id_memRead = 0; id_rd = 4; id_rs = 2; id_useRs = 1; id_A = 16'h1111;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin errors++; $display("FAIL load_use_hazard got %b want 1", hazard_stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0 || ex_memRead !== 1'b0 || hazard_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble got v=%b rw=%b mr=%b hz=%b want 0 0 0 0",
                         ex_valid, ex_regWrite, ex_memRead, hazard_stall);
    end
    memwb_regWrite = 1; memwb_rd = 2; memwb_data = 16'hBEEF;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_A !== 16'hBEEF || ex_rd !== 3'd4) begin
      errors++; $display("FAIL load_use_dep got v=%b A=%h rd=%0d want 1 BEEF 4", ex_valid, ex_A, ex_rd);
    end
  endtask

  task automatic test_capture_bypass();
    clearInputs();
    id_valid = 1; id_rt = 5; id_useRt = 1; id_B = 16'h0000;
    memwb_regWrite = 1; memwb_rd = 5; memwb_data = 16'h00FF;
    tick();
    memwb_regWrite = 0; memwb_data = 16'h7777;
    #1;
    checks++;
    if (ex_B !== 16'h00FF) begin errors++; $display("FAIL capture_bypass_B got %h want 00FF", ex_B); end
  endtask

  task automatic test_stall_flush();
    clearInputs();
    id_valid = 1; id_A = 16'h2222; id_B = 16'h3333; id_Op = 3'b011; id_rd = 6;
    id_regWrite = 1; id_invA = 1; id_Cin = 1;
    tick();
    stall_ext = 1;
    id_A = 16'h9999; id_B = 16'h8888; id_Op = 3'b001; id_rd = 1;
    id_regWrite = 0; id_invA = 0; id_Cin = 0; id_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_A !== 16'h2222 || ex_B !== 16'h3333 || ex_Op !== 3'b011 ||
          ex_rd !== 3'd6 || ex_regWrite !== 1'b1 || ex_invA !== 1'b1 || ex_Cin !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b A=%h B=%h Op=%b rd=%0d rw=%b want 1 2222 3333 011 6 1",
                           i, ex_valid, ex_A, ex_B, ex_Op, ex_rd, ex_regWrite);
      end
    end
    flush = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_regWrite !== 1'b0) begin
      errors++; $display("FAIL flush_over_stall got v=%b rw=%b want 0 0", ex_valid, ex_regWrite);
    end
    // stall_ext outranks a pending load-use bubble
    clearInputs();
    id_valid = 1; id_rd = 7; id_regWrite = 1; id_memRead = 1;
    tick();
    id_memRead = 0; id_rt = 7; id_useRt = 1; id_rd = 1;
    stall_ext = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_memRead !== 1'b1 || hazard_stall !== 1'b1) begin
      errors++; $display("FAIL stall_over_hazard got v=%b mr=%b hz=%b want 1 1 1", ex_valid, ex_memRead, hazard_stall);
    end
    flush = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_memRead !== 1'b0) begin
      errors++; $display("FAIL flush_during_hazard got v=%b mr=%b want 0 0", ex_valid, ex_memRead);
    end
  endtask

  task automatic test_immediate();
    clearInputs();
    id_valid = 1; id_useRt = 0; id_rt = 1; id_B = 16'h0007;
    exmem_regWrite = 1; exmem_rd = 1; exmem_result = 16'hDEAD;
    memwb_regWrite = 1; memwb_rd = 1; memwb_data = 16'hF00D;
    tick();
    checks++;
    if (ex_B !== 16'h0007) begin errors++; $display("FAIL immediate_B got %h want 0007", ex_B); end
  endtask

  initial begin
    clearInputs();
    rst_n = 0;
    #12 rst_n = 1;
    test_reset();
    test_forward_priority();
    test_load_use();
    test_capture_bypass();
    test_stall_flush();
    test_immediate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the execute-stage ALU. It captures decoded operands and ALU controls from decode, and forwards results from EX/MEM and MEM/WB onto the ALU A/B operands. It detects load-use hazards and inserts bubbles, and honours pipeline-wide stall and flush. All ALU-facing controls come from registers; only the forwarded operand muxes are combinational.

## Interface
- No parameters (data width fixed at 16, register index fixed at 3 bits).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_A, id_B  in  16  register-file read data (id_B already carries the immediate when applicable).
- id_rs, id_rt  in  3  source register indices.
- id_useRs, id_useRt  in  1  the instruction reads rs / rt.
- id_Op  in  3  ALU operation.
- id_invA, id_invB, id_sign, id_Cin, id_subOP  in  1 each  ALU controls.
- id_rd  in  3  destination register.
- id_regWrite, id_memRead  in  1 each  writes a register / is a load.
- exmem_regWrite  in  1  EX/MEM holds a valid register-writing instruction.
- exmem_rd  in  3  its destination register.
- exmem_result  in  16  its ALU result.
- memwb_regWrite  in  1  MEM/WB holds a valid register-writing instruction.
- memwb_rd  in  3  its destination register.
- memwb_data  in  16  its writeback data.
- stall_ext  in  1  downstream freeze of the whole pipeline.
- flush  in  1  kill the instruction entering or held in this stage.
- ex_valid  out  1  stage holds a real instruction.
- ex_A, ex_B  out  16  forwarded operands to the ALU.
- ex_Op  out  3  registered ALU control.
- ex_invA, ex_invB, ex_sign, ex_Cin, ex_subOP  out  1 each  registered ALU controls.
- ex_rd  out  3  registered destination register.
- ex_regWrite, ex_memRead  out  1 each  registered; forced 0 when ex_valid=0.
- hazard_stall  out  1  combinational; decode and fetch must hold.

## Operation
- **Reset (rst_n=0, async):** every register clears to 0, including ex_valid, ex_Op=3'b000, all controls, rd, and the captured A/B. Outputs follow from those values: ex_A=ex_B=0, hazard_stall=0.
- **hazard_stall** is asserted when all of the following hold:
  - id_valid, ex_valid, ex_memRead and ex_regWrite are all 1;
  - and either (id_useRs and id_rs==ex_rd) or (id_useRt and id_rt==ex_rd).
- **Per-edge update**, highest priority first:
  1. flush=1: ex_valid<=0, ex_regWrite<=0, ex_memRead<=0. Other fields are don't-care. Flush wins over stall_ext and hazard_stall.
  2. stall_ext=1: all registers hold.
  3. hazard_stall=1: insert a bubble (ex_valid<=0, ex_regWrite<=0, ex_memRead<=0). Decode holds its instruction and re-presents it next cycle.
  4. Otherwise capture: ex_valid<=id_valid, and all id_* fields are latched into the matching ex_* registers.
- **Capture bypass (register-file write-through):** when memwb_regWrite=1 and memwb_rd==id_rs and id_useRs=1, the captured A is memwb_data instead of id_A. The same rule applies to B with id_rt and id_useRt. This covers the same-cycle write-before-read case.
- **Execute forwarding** (combinational, computed on the registered operands; rs_q and rt_q are the registered source indices):
  - ex_A = exmem_result if exmem_regWrite and exmem_rd==rs_q and useRs_q;
  - else memwb_data if memwb_regWrite and memwb_rd==rs_q and useRs_q;
  - else the captured A.
  - ex_B uses the same chain with rt_q and useRt_q. An immediate B has useRt=0 and is never forwarded.
  - EX/MEM always takes priority over MEM/WB (youngest producer wins).
- Forwarding is not gated by ex_valid. Values seen while ex_valid=0 are don't-care to the ALU consumers.
- Register r0 has no special treatment; all 8 indices forward normally.
- Forwarding a load's result out of EX/MEM cannot occur, because the load-use stall removes that case.

## Timing
- Decode to ALU latency is 1 cycle: fields presented at edge N appear on ex_* after edge N.
- Forward muxes and hazard_stall are same-cycle combinational, with no added latency.
- A load-use hazard costs exactly 1 bubble cycle. Afterwards the dependent operand arrives via the MEM/WB forward, or via the capture bypass.
- A flush during a hazard_stall cycle clears the stage. Decode's own flush is handled by the decode stage.
- Deasserting reset mid-operation resumes capture on the first rising edge with rst_n=1.

## Test plan
- **Reset:** assert rst_n=0 asynchronously mid-cycle -> ex_valid=0, ex_Op=0, ex_A=ex_B=0 immediately. After release, first capture of id_A=16'h1234, id_Op=3'b100 -> ex_A=16'h1234, ex_Op=3'b100 next cycle.
- **Forward priority:** captured A=16'h0001, rs=3. exmem (rd=3, result 16'hAAAA) and memwb (rd=3, data 16'h5555) both valid -> ex_A=16'hAAAA. Drop exmem_regWrite -> ex_A=16'h5555.
- **Load-use:** EX holds a load to rd=2; id uses rs=2 -> hazard_stall=1, ex_valid=0 after the edge, id held. Next cycle memwb_rd=2 with data 16'hBEEF -> dependent instruction ex_A=16'hBEEF.
- **Capture bypass:** id_rt=5, id_useRt=1, id_B=16'h0000, memwb (rd=5, data 16'h00FF) in the same cycle -> ex_B=16'h00FF after the edge with no forward active.
- **Stall/flush:** stall_ext=1 for 3 cycles -> all ex_* hold. Then flush=1 together with stall_ext=1 -> ex_valid=0, ex_regWrite=0.
- **Immediate:** id_useRt=0, id_B=16'h0007, exmem_rd==id_rt -> ex_B stays 16'h0007.
